// File: rtl/oversample_phase_picker_if.sv
// Window-in / recovered-bits-out bundle of the oversampling phase picker.
// The bench or upstream logic takes the master side; the picker takes the slave side.
interface oversample_phase_picker_if;
    logic [7:0] din;
    logic       din_valid;
    logic [2:0] dout;
    logic [1:0] dout_cnt;
    logic       dout_valid;
    logic [1:0] phase;
    logic       locked;

    modport master (
        output din, din_valid,
        input  dout, dout_cnt, dout_valid, phase, locked
    );

    modport slave (
        input  din, din_valid,
        output dout, dout_cnt, dout_valid, phase, locked
    );
endinterface

// File: rtl/oversample_phase_picker.sv
// 4x-oversampled data recovery: edge detect per 8-sample window, phase voting and
// 1/2/3-bit extraction depending on whether the sampling phase wrapped.
module oversample_phase_picker #(
    parameter int unsigned VOTE_THRESH = 4,
    parameter int unsigned LOCK_CYCLES = 64,
    parameter int unsigned INIT_PHASE  = 2
) (
    input  logic                     clk,
    input  logic                     aresetn,
    oversample_phase_picker_if.slave bus
);

    localparam int unsigned VOTE_W = 4;
    localparam int unsigned LOCK_W = 8;
    localparam logic [VOTE_W-1:0] VOTE_MAX  = VOTE_W'(VOTE_THRESH);
    localparam logic [LOCK_W-1:0] LOCK_MAX  = LOCK_W'(LOCK_CYCLES);
    localparam logic [1:0]        PHASE_RST = 2'(INIT_PHASE);

    // S1 state
    logic [7:0]        r_s1;
    logic [3:0]        r_e1;
    logic              r_p7_s1;
    logic              r_v1;
    logic              r_p7;
    logic              r_first;

    // S2 state
    logic [1:0]        r_ph;
    logic [VOTE_W-1:0] r_up;
    logic [VOTE_W-1:0] r_dn;
    logic [LOCK_W-1:0] r_stab;
    logic              r_wrap_up;
    logic              r_wrap_dn;
    logic [2:0]        r_dout;
    logic [1:0]        r_dout_cnt;
    logic              r_dout_valid;
    logic              r_locked;

    logic [3:0]        w_edge;
    logic              w_vote;
    logic [1:0]        w_k;
    logic [1:0]        w_dist;
    logic [VOTE_W-1:0] w_up_n;
    logic [VOTE_W-1:0] w_dn_n;
    logic              w_step_up;
    logic              w_step_dn;
    logic [LOCK_W-1:0] w_stab_n;
    logic [2:0]        w_dout;
    logic [1:0]        w_dout_cnt;

    // Transitions into sample k of either UI half; e[0] also looks back at the previous window.
    always_comb begin
        w_edge[0] = (bus.din[0] ^ r_p7)       | (bus.din[4] ^ bus.din[3]);
        w_edge[1] = (bus.din[1] ^ bus.din[0]) | (bus.din[5] ^ bus.din[4]);
        w_edge[2] = (bus.din[2] ^ bus.din[1]) | (bus.din[6] ^ bus.din[5]);
        w_edge[3] = (bus.din[3] ^ bus.din[2]) | (bus.din[7] ^ bus.din[6]);
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_s1    <= '0;
            r_e1    <= '0;
            r_p7_s1 <= 1'b0;
            r_v1    <= 1'b0;
            r_p7    <= 1'b0;
            r_first <= 1'b1;
        end else begin
            r_v1 <= bus.din_valid;
            if (bus.din_valid) begin
                r_s1    <= bus.din;
                r_e1    <= r_first ? 4'b0000 : w_edge;
                r_p7_s1 <= r_p7;
                r_p7    <= bus.din[7];
                r_first <= 1'b0;
            end
        end
    end

    // Only an unambiguous single edge votes; the ideal phase sits two samples after it.
    always_comb begin
        w_vote = 1'b1;
        w_k    = 2'd0;
        case (r_e1)
            4'b0001: w_k = 2'd0;
            4'b0010: w_k = 2'd1;
            4'b0100: w_k = 2'd2;
            4'b1000: w_k = 2'd3;
            default: w_vote = 1'b0;
        endcase
        w_dist = (w_k + 2'd2) - r_ph;

        w_up_n = r_up;
        w_dn_n = r_dn;
        if (w_vote && (w_dist == 2'd1)) begin
            w_up_n = r_up + 4'd1;
            w_dn_n = '0;
        end else if (w_vote && (w_dist == 2'd3)) begin
            w_dn_n = r_dn + 4'd1;
            w_up_n = '0;
        end
        w_step_up = (w_up_n == VOTE_MAX);
        w_step_dn = (w_dn_n == VOTE_MAX);

        if (w_step_up || w_step_dn) begin
            w_stab_n = '0;
        end else if (r_stab == LOCK_MAX) begin
            w_stab_n = r_stab;
        end else begin
            w_stab_n = r_stab + 8'd1;
        end
    end

    // A wrap either skips the too-close sample or borrows the previous window's last one.
    always_comb begin
        w_dout     = {1'b0, r_s1[{1'b1, r_ph}], r_s1[{1'b0, r_ph}]};
        w_dout_cnt = 2'd2;
        if (r_wrap_up) begin
            w_dout     = {2'b00, r_s1[4]};
            w_dout_cnt = 2'd1;
        end else if (r_wrap_dn) begin
            w_dout     = {r_s1[7], r_s1[3], r_p7_s1};
            w_dout_cnt = 2'd3;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_ph         <= PHASE_RST;
            r_up         <= '0;
            r_dn         <= '0;
            r_stab       <= '0;
            r_wrap_up    <= 1'b0;
            r_wrap_dn    <= 1'b0;
            r_dout       <= '0;
            r_dout_cnt   <= '0;
            r_dout_valid <= 1'b0;
            r_locked     <= 1'b0;
        end else begin
            r_dout_valid <= r_v1;
            if (r_v1) begin
                r_dout     <= w_dout;
                r_dout_cnt <= w_dout_cnt;
                r_up       <= (w_step_up || w_step_dn) ? '0 : w_up_n;
                r_dn       <= (w_step_up || w_step_dn) ? '0 : w_dn_n;
                r_stab     <= w_stab_n;
                r_locked   <= (w_stab_n == LOCK_MAX);
                r_wrap_up  <= w_step_up && (r_ph == 2'd3);
                r_wrap_dn  <= w_step_dn && (r_ph == 2'd0);
                if (w_step_up) begin
                    r_ph <= r_ph + 2'd1;
                end else if (w_step_dn) begin
                    r_ph <= r_ph - 2'd1;
                end
            end
        end
    end

    assign bus.dout       = r_dout;
    assign bus.dout_cnt   = r_dout_cnt;
    assign bus.dout_valid = r_dout_valid;
    assign bus.phase      = r_ph;
    assign bus.locked     = r_locked;

endmodule
